// File: rtl/disp_pkg.sv
// disp_pkg: glyph codes, message table, FSM states and display-source codes for the display scheduler
package disp_pkg;
  localparam logic [3:0] GLYPH_E = 4'hA;
  localparam logic [3:0] GLYPH_R = 4'hB;
  localparam logic [3:0] GLYPH_N = 4'hC;
  localparam logic [3:0] GLYPH_O = 4'hD;
  localparam logic [3:0] GLYPH_DASH = 4'hE;
  localparam logic [3:0] GLYPH_BLANK = 4'hF;
  localparam logic [15:0] MSG_TABLE [4] = '{
    {GLYPH_E, GLYPH_R, GLYPH_R, GLYPH_BLANK},
    {GLYPH_DASH, GLYPH_DASH, GLYPH_DASH, GLYPH_DASH},
    {GLYPH_N, GLYPH_O, GLYPH_N, GLYPH_E},
    {GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK}
  };
  typedef enum logic [1:0] {S_CREDIT, S_PRICE_CONV, S_PRICE, S_MSG} state_t;
  localparam logic [1:0] SRC_CREDIT = 2'd0;
  localparam logic [1:0] SRC_PRICE = 2'd1;
  localparam logic [1:0] SRC_MSG = 2'd2;
  function automatic logic [15:0] blank_lead(input logic [15:0] b);
    return b[15:12] == 4'd0 ? {GLYPH_BLANK, b[11:0]} : b;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, saturating at 9999, one load cycle then W shifts
module bin2bcd_seq #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [15:0]  bcd
);
  logic [W-1:0] sr;
  logic [15:0] acc;
  logic [$clog2(W+1)-1:0] cnt;
  logic [W+15:0] sh;
  function automatic logic [15:0] dab(input logic [15:0] a);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i+:4] = a[4*i+:4] > 4'd4 ? a[4*i+:4] + 4'd3 : a[4*i+:4];
    return r;
  endfunction
  assign sh = {dab(acc), sr} << 1;
  always_ff @(posedge clk) begin
    if (clr) begin
      busy <= 1'b0;
      done <= 1'b0;
      bcd <= '0;
      acc <= '0;
      sr <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        acc <= sh[W+15:W];
        sr <= sh[W-1:0];
        cnt <= cnt - 1'b1;
        if (cnt == 1) begin
          busy <= 1'b0;
          done <= 1'b1;
          bcd <= sh[W+15:W];
        end
      end else if (start) begin
        sr <= (bin > 9999) ? W'(9999) : bin;
        acc <= '0;
        cnt <= ($clog2(W+1))'(W);
        busy <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/disp_content_sched.sv
// disp_content_sched: arbitrates message > price > credit onto the 4-digit display via one shared BCD converter
module disp_content_sched import disp_pkg::*; #(
  parameter int MSG_TICKS = 200_000_000,
  parameter int PRICE_TICKS = 100_000_000,
  parameter int VAL_W = 14
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [VAL_W-1:0] credit_cents,
  input  logic             price_req,
  input  logic [VAL_W-1:0] price_cents,
  input  logic             msg_req,
  input  logic [1:0]       msg_code,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3,
  output logic [3:0]       dig4,
  output logic [1:0]       disp_src,
  output logic             busy
);
  localparam int MAXT = MSG_TICKS > PRICE_TICKS ? MSG_TICKS : PRICE_TICKS;
  localparam int TW = $clog2(MAXT);
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [VAL_W-1:0] pval, pval_n, lc, lc_n, cval, cval_n, cbin;
  logic pend, pend_n, lcv, lcv_n, job, job_n, start, cbusy, cdone;
  logic [15:0] dig, dig_n, bcd;
  bin2bcd_seq #(.W(VAL_W)) u_conv (
    .clk(clk), .clr(clr), .start(start), .bin(cbin),
    .busy(cbusy), .done(cdone), .bcd(bcd)
  );
  assign {dig1, dig2, dig3, dig4} = dig;
  always_comb begin
    state_n = state;
    timer_n = timer == '0 ? timer : timer - 1'b1;
    pend_n = pend;
    pval_n = pval;
    lc_n = lc;
    lcv_n = lcv;
    job_n = job;
    cval_n = cval;
    dig_n = dig;
    // job: 1 = price conversion, 0 = credit conversion; results are only accepted in the matching state
    start = !cbusy && !cdone && state != S_MSG && (pend || (state == S_CREDIT && (!lcv || credit_cents != lc)));
    cbin = pend ? pval : credit_cents;
    if (start) begin
      job_n = pend;
      cval_n = credit_cents;
      pend_n = 1'b0;
    end
    if (cdone && job && state == S_PRICE_CONV && !pend) begin
      dig_n = blank_lead(bcd);
      timer_n = TW'(PRICE_TICKS - 1);
      state_n = S_PRICE;
    end else if (cdone && !job && state == S_CREDIT && !pend) begin
      dig_n = blank_lead(bcd);
      lc_n = cval;
      lcv_n = 1'b1;
    end
    if (state == S_PRICE && timer == '0) begin
      state_n = S_CREDIT;
      lcv_n = 1'b0;
    end
    if (state == S_MSG && timer == '0) begin
      state_n = pend ? S_PRICE_CONV : S_CREDIT;
      lcv_n = 1'b0;
    end
    if (price_req) begin
      pend_n = 1'b1;
      pval_n = price_cents;
      state_n = state_n == S_MSG ? S_MSG : S_PRICE_CONV;
    end
    if (msg_req) begin
      state_n = S_MSG;
      timer_n = TW'(MSG_TICKS - 1);
      dig_n = MSG_TABLE[msg_code];
      if (state == S_PRICE_CONV) pend_n = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_CREDIT;
      timer <= '0;
      pend <= 1'b0;
      pval <= '0;
      lc <= '0;
      lcv <= 1'b0;
      job <= 1'b0;
      cval <= '0;
      dig <= {4{GLYPH_BLANK}};
      disp_src <= SRC_CREDIT;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      pend <= pend_n;
      pval <= pval_n;
      lc <= lc_n;
      lcv <= lcv_n;
      job <= job_n;
      cval <= cval_n;
      dig <= dig_n;
      disp_src <= state_n == S_MSG ? SRC_MSG : state_n == S_CREDIT ? SRC_CREDIT : SRC_PRICE;
      busy <= state_n != S_CREDIT || pend_n;
    end
  end
endmodule
